// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data memory, byte/half/word load-store, MEM/WB register
//
// Purpose:
//   Takes one instruction per cycle from the EX/MEM register.
//   Stores are written into a word-organised data memory with byte enables.
//   Loads read the addressed word combinationally and extract and extend the
//   selected byte or half. The writeback value and the pass-through control
//   fields are registered into MEM/WB, giving one cycle of latency.
//
// Optional feature:
//   MEM_MISALIGN_TRAP_EN - when defined, misaligned half/word accesses are
//   flagged on misalign_out. Misaligned stores are suppressed, and misaligned
//   loads have their register write killed. When undefined, misalign_out is
//   tied 0 and the offset bits below the access size are ignored.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset of the MEM/WB outputs
//   stall_in      hold all outputs and block memory writes
//   flush_in      squash the incoming instruction (outputs go to reset values)
//   data_1_in     ALU result / byte address
//   data_2_in     store data, right-aligned
//   Rd_in         destination register
//   funct3_in     access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   MEM_wen_in    store enable
//   WB_sel_in     1 = load result to WB, 0 = data_1_in to WB
//   Reg_WB_in     register write enable
//   auipc_in      AUIPC flag, passed through
//   wb_data_out   registered writeback value
//   Rd_out        registered destination register
//   Reg_WB_out    registered register write enable
//   auipc_out     registered AUIPC flag
//   misalign_out  registered misaligned-access flag

module mem_stage #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [31:0] data_1_in,
  input  logic [31:0] data_2_in,
  input  logic [4:0]  Rd_in,
  input  logic [2:0]  funct3_in,
  input  logic        MEM_wen_in,
  input  logic        WB_sel_in,
  input  logic        Reg_WB_in,
  input  logic        auipc_in,
  output logic [31:0] wb_data_out,
  output logic [4:0]  Rd_out,
  output logic        Reg_WB_out,
  output logic        auipc_out,
  output logic        misalign_out
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] word_idx;
  logic [1:0]    byte_off;
  logic          in_range;
  logic          size_byte;
  logic          size_half;
  logic          size_word;
  logic          is_unsigned;
  logic          is_access;
  logic          is_load;
  logic          misaligned;
  logic          load_trap;
  logic          store_en;
  logic [3:0]    byte_en;
  logic [31:0]   store_word;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_val;
  logic [31:0]   wb_next;
  logic          reg_wb_next;
  logic          misalign_next;

  assign word_idx = data_1_in[AW+1:2];
  assign byte_off = data_1_in[1:0];
  assign in_range = (data_1_in[31:AW+2] == '0);

  // funct3[1:0] picks the size; the reserved encodings 011/110/111 fall into
  // the word bucket. funct3[2] only matters for byte/half extension.
  assign size_byte   = (funct3_in[1:0] == 2'b00);
  assign size_half   = (funct3_in[1:0] == 2'b01);
  assign size_word   = funct3_in[1];
  assign is_unsigned = funct3_in[2];

  assign is_access = MEM_wen_in | WB_sel_in;
  // A store with WB_sel_in also set is treated as a store that writes back
  // the ALU result, so only a pure load uses the memory read path.
  assign is_load   = WB_sel_in & ~MEM_wen_in;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = is_access &
                      ((size_half & data_1_in[0]) |
                       (size_word & (data_1_in[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign load_trap = is_load & misaligned;

  // Reset, stall and flush all block the write of the current instruction.
  assign store_en = MEM_wen_in & in_range & ~misaligned &
                    ~reset & ~stall_in & ~flush_in;

  // Store data is replicated across lanes so each enabled lane simply takes
  // its own slice; the byte enables decide which lanes actually change.
  always_comb begin
    byte_en    = 4'b0000;
    store_word = data_2_in;
    if (size_byte) begin
      byte_en    = 4'b0001 << byte_off;
      store_word = {4{data_2_in[7:0]}};
    end else if (size_half) begin
      byte_en    = data_1_in[1] ? 4'b1100 : 4'b0011;
      store_word = {2{data_2_in[15:0]}};
    end else begin
      byte_en    = 4'b1111;
      store_word = data_2_in;
    end
  end

  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
        end
      end
    end
  end

  // Asynchronous read: a store at edge N is visible to a load consumed at
  // edge N+1 without any forwarding path.
  assign rd_word = mem[word_idx];

  always_comb begin
    rd_byte = 8'h00;
    case (byte_off)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
  end

  assign rd_half = data_1_in[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = 32'h0;
    if (!in_range) begin
      load_val = 32'h0;
    end else if (size_byte) begin
      load_val = is_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
    end else if (size_half) begin
      load_val = is_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
    end else begin
      load_val = rd_word;
    end
  end

  always_comb begin
    wb_next       = data_1_in;
    reg_wb_next   = Reg_WB_in & ~load_trap;
    misalign_next = misaligned;
    if (is_load) begin
      wb_next = load_trap ? 32'h0 : load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_data_out  <= 32'h0;
      Rd_out       <= 5'd0;
      Reg_WB_out   <= 1'b0;
      auipc_out    <= 1'b0;
      misalign_out <= 1'b0;
    end else if (stall_in) begin
      wb_data_out  <= wb_data_out;
      Rd_out       <= Rd_out;
      Reg_WB_out   <= Reg_WB_out;
      auipc_out    <= auipc_out;
      misalign_out <= misalign_out;
    end else if (flush_in) begin
      wb_data_out  <= 32'h0;
      Rd_out       <= 5'd0;
      Reg_WB_out   <= 1'b0;
      auipc_out    <= 1'b0;
      misalign_out <= 1'b0;
    end else begin
      wb_data_out  <= wb_next;
      Rd_out       <= Rd_in;
      Reg_WB_out   <= reg_wb_next;
      auipc_out    <= auipc_in;
      misalign_out <= misalign_next;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage

module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        flush_in;
  logic [31:0] data_1_in;
  logic [31:0] data_2_in;
  logic [4:0]  Rd_in;
  logic [2:0]  funct3_in;
  logic        MEM_wen_in;
  logic        WB_sel_in;
  logic        Reg_WB_in;
  logic        auipc_in;
  logic [31:0] wb_data_out;
  logic [4:0]  Rd_out;
  logic        Reg_WB_out;
  logic        auipc_out;
  logic        misalign_out;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.DEPTH(1024)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_in     (stall_in),
    .flush_in     (flush_in),
    .data_1_in    (data_1_in),
    .data_2_in    (data_2_in),
    .Rd_in        (Rd_in),
    .funct3_in    (funct3_in),
    .MEM_wen_in   (MEM_wen_in),
    .WB_sel_in    (WB_sel_in),
    .Reg_WB_in    (Reg_WB_in),
    .auipc_in     (auipc_in),
    .wb_data_out  (wb_data_out),
    .Rd_out       (Rd_out),
    .Reg_WB_out   (Reg_WB_out),
    .auipc_out    (auipc_out),
    .misalign_out (misalign_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic mw, input logic ws, input logic rwb,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd);
    MEM_wen_in = mw;
    WB_sel_in  = ws;
    Reg_WB_in  = rwb;
    funct3_in  = f3;
    data_1_in  = a;
    data_2_in  = d;
    Rd_in      = rd;
    auipc_in   = 1'b0;
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b0, 1'b0, 3'b010, 32'h40, 32'h11111111, 5'd0);
    tick();
    reset = 1'b1;
    set_in(1'b1, 1'b0, 1'b1, 3'b010, 32'h40, 32'hAAAAAAAA, 5'd5);
    auipc_in = 1'b1;
    tick();
    tick();
    n_checks++; if (wb_data_out !== 32'h0) begin n_fail++; $display("FAIL reset_wb: got %h expected %h", wb_data_out, 32'h0); end
    n_checks++; if (Rd_out !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d expected 0", Rd_out); end
    n_checks++; if (Reg_WB_out !== 1'b0) begin n_fail++; $display("FAIL reset_regwb: got %b expected 0", Reg_WB_out); end
    n_checks++; if (auipc_out !== 1'b0) begin n_fail++; $display("FAIL reset_auipc: got %b expected 0", auipc_out); end
    n_checks++; if (misalign_out !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", misalign_out); end
    reset = 1'b0;
    set_in(1'b0, 1'b1, 1'b1, 3'b010, 32'h40, 32'h0, 5'd1);
    tick();
    n_checks++; if (wb_data_out !== 32'h11111111) begin n_fail++; $display("FAIL reset_no_write: got %h expected %h", wb_data_out, 32'h11111111); end
  endtask

  task automatic test_sizes();
    set_in(1'b1, 1'b0, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);
    tick();
    n_checks++; if (wb_data_out !== 32'h10) begin n_fail++; $display("FAIL sw_wb_addr: got %h expected %h", wb_data_out, 32'h10); end
    set_in(1'b0, 1'b1, 1'b1, 3'b000, 32'h13, 32'h0, 5'd2);
    tick();
    n_checks++; if (wb_data_out !== 32'hFFFFFFDE) begin n_fail++; $display("FAIL lb_13: got %h expected %h", wb_data_out, 32'hFFFFFFDE); end
    n_checks++; if (Rd_out !== 5'd2 || Reg_WB_out !== 1'b1) begin n_fail++; $display("FAIL lb_ctrl: got rd=%0d regwb=%b expected rd=2 regwb=1", Rd_out, Reg_WB_out); end
    set_in(1'b0, 1'b1, 1'b1, 3'b100, 32'h10, 32'h0, 5'd3);
    tick();
    n_checks++; if (wb_data_out !== 32'h000000EF) begin n_fail++; $display("FAIL lbu_10: got %h expected %h", wb_data_out, 32'h000000EF); end
    set_in(1'b0, 1'b1, 1'b1, 3'b001, 32'h12, 32'h0, 5'd4);
    tick();
    n_checks++; if (wb_data_out !== 32'hFFFFDEAD) begin n_fail++; $display("FAIL lh_12: got %h expected %h", wb_data_out, 32'hFFFFDEAD); end
    set_in(1'b0, 1'b1, 1'b1, 3'b101, 32'h10, 32'h0, 5'd5);
    tick();
    n_checks++; if (wb_data_out !== 32'h0000BEEF) begin n_fail++; $display("FAIL lhu_10: got %h expected %h", wb_data_out, 32'h0000BEEF); end
    set_in(1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'h0, 5'd6);
    tick();
    n_checks++; if (wb_data_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_10: got %h expected %h", wb_data_out, 32'hDEADBEEF); end
    set_in(1'b0, 1'b1, 1'b1, 3'b111, 32'h10, 32'h0, 5'd6);
    tick();
    n_checks++; if (wb_data_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_f3_111: got %h expected %h", wb_data_out, 32'hDEADBEEF); end
  endtask

  task automatic test_partial_store();
    set_in(1'b1, 1'b0, 1'b0, 3'b000, 32'h11, 32'hFFFFFF55, 5'd0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'h0, 5'd8);
    tick();
    n_checks++; if (wb_data_out !== 32'hDEAD55EF) begin n_fail++; $display("FAIL sb_11: got %h expected %h", wb_data_out, 32'hDEAD55EF); end
    set_in(1'b1, 1'b0, 1'b0, 3'b001, 32'h12, 32'h1234CAFE, 5'd0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'h0, 5'd8);
    tick();
    n_checks++; if (wb_data_out !== 32'hCAFE55EF) begin n_fail++; $display("FAIL sh_12: got %h expected %h", wb_data_out, 32'hCAFE55EF); end
  endtask

  task automatic test_back_to_back();
    set_in(1'b1, 1'b0, 1'b0, 3'b010, 32'h20, 32'h12345678, 5'd0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 3'b010, 32'h20, 32'h0, 5'd10);
    tick();
    n_checks++; if (wb_data_out !== 32'h12345678) begin n_fail++; $display("FAIL b2b_lw_20: got %h expected %h", wb_data_out, 32'h12345678); end
    set_in(1'b0, 1'b0, 1'b1, 3'b000, 32'h42, 32'h0, 5'd7);
    auipc_in = 1'b1;
    tick();
    n_checks++; if (wb_data_out !== 32'h42) begin n_fail++; $display("FAIL alu_wb: got %h expected %h", wb_data_out, 32'h42); end
    n_checks++; if (Rd_out !== 5'd7 || Reg_WB_out !== 1'b1 || auipc_out !== 1'b1) begin n_fail++; $display("FAIL alu_ctrl: got rd=%0d regwb=%b auipc=%b expected rd=7 regwb=1 auipc=1", Rd_out, Reg_WB_out, auipc_out); end
    set_in(1'b1, 1'b1, 1'b1, 3'b010, 32'h50, 32'h5555AAAA, 5'd11);
    tick();
    n_checks++; if (wb_data_out !== 32'h50) begin n_fail++; $display("FAIL illegal_wb: got %h expected %h", wb_data_out, 32'h50); end
    set_in(1'b0, 1'b1, 1'b1, 3'b010, 32'h50, 32'h0, 5'd11);
    tick();
    n_checks++; if (wb_data_out !== 32'h5555AAAA) begin n_fail++; $display("FAIL illegal_store: got %h expected %h", wb_data_out, 32'h5555AAAA); end
  endtask

  task automatic test_stall_flush();
    set_in(1'b1, 1'b0, 1'b0, 3'b010, 32'h30, 32'hCAFEF00D, 5'd0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 3'b010, 32'h30, 32'h0, 5'd9);
    tick();
    n_checks++; if (wb_data_out !== 32'hCAFEF00D) begin n_fail++; $display("FAIL pre_stall_lw: got %h expected %h", wb_data_out, 32'hCAFEF00D); end
    stall_in = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 3'b010, 32'h30, 32'h99999999, 5'd3);
    tick();
    tick();
    n_checks++; if (wb_data_out !== 32'hCAFEF00D || Rd_out !== 5'd9 || Reg_WB_out !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got wb=%h rd=%0d regwb=%b expected wb=cafef00d rd=9 regwb=1", wb_data_out, Rd_out, Reg_WB_out); end
    stall_in = 1'b0;
    flush_in = 1'b1;
    set_in(1'b1, 1'b0, 1'b1, 3'b010, 32'h30, 32'h00000001, 5'd4);
    tick();
    n_checks++; if (wb_data_out !== 32'h0 || Rd_out !== 5'd0 || Reg_WB_out !== 1'b0) begin n_fail++; $display("FAIL flush_out: got wb=%h rd=%0d regwb=%b expected 0 0 0", wb_data_out, Rd_out, Reg_WB_out); end
    flush_in = 1'b0;
    set_in(1'b0, 1'b1, 1'b1, 3'b010, 32'h30, 32'h0, 5'd9);
    tick();
    n_checks++; if (wb_data_out !== 32'hCAFEF00D) begin n_fail++; $display("FAIL post_flush_lw: got %h expected %h", wb_data_out, 32'hCAFEF00D); end
  endtask

  task automatic test_misalign();
    set_in(1'b1, 1'b0, 1'b0, 3'b010, 32'h21, 32'hA5A5A5A5, 5'd0);
    tick();
`ifdef MEM_MISALIGN_TRAP_EN
    n_checks++; if (misalign_out !== 1'b1) begin n_fail++; $display("FAIL sw_21_flag: got %b expected 1", misalign_out); end
    set_in(1'b0, 1'b1, 1'b1, 3'b010, 32'h20, 32'h0, 5'd12);
    tick();
    n_checks++; if (wb_data_out !== 32'h12345678) begin n_fail++; $display("FAIL sw_21_word: got %h expected %h", wb_data_out, 32'h12345678); end
    n_checks++; if (misalign_out !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got %b expected 0", misalign_out); end
    set_in(1'b0, 1'b1, 1'b1, 3'b001, 32'h23, 32'h0, 5'd13);
    tick();
    n_checks++; if (misalign_out !== 1'b1 || Reg_WB_out !== 1'b0 || wb_data_out !== 32'h0) begin n_fail++; $display("FAIL lh_23_trap: got flag=%b regwb=%b wb=%h expected 1 0 0", misalign_out, Reg_WB_out, wb_data_out); end
`else
    n_checks++; if (misalign_out !== 1'b0) begin n_fail++; $display("FAIL sw_21_flag: got %b expected 0", misalign_out); end
    set_in(1'b0, 1'b1, 1'b1, 3'b010, 32'h20, 32'h0, 5'd12);
    tick();
    n_checks++; if (wb_data_out !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sw_21_word: got %h expected %h", wb_data_out, 32'hA5A5A5A5); end
    set_in(1'b1, 1'b0, 1'b0, 3'b001, 32'h21, 32'h00008001, 5'd0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 3'b001, 32'h23, 32'h0, 5'd13);
    tick();
    n_checks++; if (wb_data_out !== 32'hFFFFA5A5 || misalign_out !== 1'b0 || Reg_WB_out !== 1'b1) begin n_fail++; $display("FAIL lh_23_upper: got wb=%h flag=%b regwb=%b expected ffffa5a5 0 1", wb_data_out, misalign_out, Reg_WB_out); end
    set_in(1'b0, 1'b1, 1'b1, 3'b010, 32'h22, 32'h0, 5'd13);
    tick();
    n_checks++; if (wb_data_out !== 32'hA5A58001) begin n_fail++; $display("FAIL lw_22_aligned: got %h expected %h", wb_data_out, 32'hA5A58001); end
`endif
  endtask

  task automatic test_out_of_range();
    set_in(1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0BADF00D, 5'd0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 3'b010, 32'h1000, 32'h0, 5'd14);
    tick();
    n_checks++; if (wb_data_out !== 32'h0 || Rd_out !== 5'd14 || Reg_WB_out !== 1'b1) begin n_fail++; $display("FAIL oor_lw: got wb=%h rd=%0d regwb=%b expected 0 14 1", wb_data_out, Rd_out, Reg_WB_out); end
    set_in(1'b1, 1'b0, 1'b0, 3'b010, 32'h1010, 32'h77777777, 5'd0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'h0, 5'd15);
    tick();
    n_checks++; if (wb_data_out !== 32'hCAFE55EF) begin n_fail++; $display("FAIL oor_sw_dropped: got %h expected %h", wb_data_out, 32'hCAFE55EF); end
  endtask

  initial begin
    reset    = 1'b0;
    stall_in = 1'b0;
    flush_in = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    test_reset();
    test_sizes();
    test_partial_store();
    test_back_to_back();
    test_stall_flush();
    test_misalign();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage, fed directly by the EX/MEM pipeline register.
- Holds the word-organised data memory and performs byte-addressed loads and stores of byte, half and word size.
- Selects the writeback value and registers the MEM/WB outputs that feed the WB stage.
- Single-issue, one instruction per cycle, one-cycle latency from inputs to outputs.

Parameters:
- DEPTH, 1024, number of 32-bit words in data memory. Power of two; word index is data_1_in[log2(DEPTH)+1:2].

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- stall_in  input  1  hold stage: no memory write, outputs hold
- flush_in  input  1  squash the incoming instruction
- data_1_in  input  32  ALU result; byte address for loads/stores
- data_2_in  input  32  store data, right-aligned
- Rd_in  input  5  destination register
- funct3_in  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- MEM_wen_in  input  1  store
- WB_sel_in  input  1  1 = load result to WB, 0 = data_1_in to WB
- Reg_WB_in  input  1  register write enable
- auipc_in  input  1  AUIPC flag, passed through
- wb_data_out  output  32  writeback value
- Rd_out  output  5  registered Rd
- Reg_WB_out  output  1  registered write enable
- auipc_out  output  1  registered AUIPC flag
- misalign_out  output  1  misaligned access flag (see Optional Feature)

Behaviour:
- Reset: all outputs 0 on the first clk edge with reset=1. Memory contents are not cleared.
- Priority at each edge: reset > stall_in > flush_in > normal.
- stall_in=1:
  - All outputs hold.
  - No memory write, even if MEM_wen_in=1.
- flush_in=1 (no stall):
  - No memory write.
  - Outputs take reset values: Reg_WB_out=0, Rd_out=0, wb_data_out=0, auipc_out=0, misalign_out=0.
- Normal edge, in which inputs are consumed and outputs update at the same posedge (latency 1):
  - Store, MEM_wen_in=1:
    - SB writes byte lane data_1_in[1:0] with data_2_in[7:0].
    - SH writes lanes {data_1_in[1],0} and +1 with data_2_in[15:0], little-endian.
    - SW writes the whole word.
    - Other lanes are unchanged.
  - Load, WB_sel_in=1:
    - Read the addressed word and extract the byte/half at the address offset.
    - B and H sign-extend; BU and HU zero-extend; W is unmodified.
    - funct3 values 011, 110, 111 are treated as W.
  - WB_sel_in=0: wb_data_out = data_1_in.
  - Rd_out, Reg_WB_out and auipc_out copy their inputs.
- Store followed by a load to the same address on the next cycle returns the newly stored data (write lands at edge N, read at edge N+1).
- Out of range (data_1_in[31:log2(DEPTH)+2] != 0):
  - Stores are dropped.
  - Loads return 0.
  - Pipeline outputs behave otherwise normally.
- MEM_wen_in=1 and WB_sel_in=1 together is illegal. Required result: store is performed and wb_data_out = data_1_in.
- Reset asserted mid-stream: the instruction present that cycle is not written to memory.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN
- Defined:
  - An access is misaligned when H/HU has data_1_in[0]=1, or W has data_1_in[1:0]!=0.
  - A misaligned store is suppressed.
  - A misaligned load forces Reg_WB_out=0 and wb_data_out=0.
  - misalign_out=1 for exactly that output cycle.
- Not defined:
  - misalign_out is tied 0.
  - Offset bits below the access size are ignored: H uses data_1_in[1], W uses the aligned word.

Test Plan:
- Reset: drive inputs non-zero with reset=1 for 2 cycles -> all outputs 0.
- Sizes and extension:
  - SW 0xDEADBEEF to address 0x10, then LB 0x13 -> 0xFFFFFFDE.
  - LBU 0x10 -> 0x000000EF.
  - LH 0x12 -> 0xFFFFDEAD.
  - LHU 0x10 -> 0x0000BEEF.
  - LW 0x10 -> 0xDEADBEEF.
- Partial store: SB 0x55 to 0x11 over 0xDEADBEEF -> LW 0x10 returns 0xDEAD55EF.
- Back-to-back: SW 0x12345678 to 0x20 followed next cycle by LW 0x20 -> 0x12345678.
  - Also: ALU op with WB_sel_in=0, data_1_in=0x42, Rd_in=7 -> wb_data_out=0x42, Rd_out=7 one cycle later.
- Stall/flush:
  - stall_in=1 with SW to 0x30 -> memory unchanged, outputs hold prior values.
  - flush_in=1 with SW 0x1 to 0x30 -> store dropped, Reg_WB_out=0.
  - LW 0x30 afterwards -> original value.
- Misalign:
  - With MEM_MISALIGN_TRAP_EN, SW to 0x21 -> misalign_out=1, word 0x20 unchanged.
  - Without the macro, SW to 0x21 writes word 0x20 and misalign_out=0.
  - Out-of-range LW at address DEPTH*4 -> 0.
